mem_stage: RTL
==============

# mem_stage

Memory-access stage sitting directly downstream of the execute-stage ALU. It consumes the ALU result, ALU op and overflow flag each cycle. For `ALUOP_LDB`/`LDW`/`STB`/`STW` it runs a request/acknowledge transaction with the data cache and stalls execute until that transaction completes. All other ops pass through to write-back with one registered cycle of latency.

## Interface
- `REG_SIZE`, 32, datapath width; only 32 is supported (4 byte lanes).
- `clk` input 1: clock; everything updates on the rising edge.
- `rst_n` input 1: synchronous reset, active low.
- `ex_valid` input 1: execute presents an op this cycle.
- `ex_ready` output 1: stage accepts the op; the op transfers when `ex_valid && ex_ready`.
- `ex_aluop` input 5: ALU op code, `ALUOP_*` from define.v.
- `ex_alu_out` input REG_SIZE: ALU result; this is the byte address for memory ops.
- `ex_store_data` input REG_SIZE: rt value to store.
- `ex_rd` input 5: destination register.
- `ex_regwrite` input 1: op writes `rd`.
- `ex_overflow` input 1: ALU overflow flag.
- `flush` input 1: kill the in-flight op (exception or iret).
- `dc_req` output 1: cache request.
- `dc_we` output 1: 1 = store.
- `dc_addr` output REG_SIZE: word address, bits [1:0] forced to 0.
- `dc_wdata` output REG_SIZE: store data.
- `dc_be` output 4: byte enables.
- `dc_ack` input 1: cache done; `dc_rdata` is valid in the same cycle.
- `dc_rdata` input REG_SIZE: load word.
- `wb_valid` output 1: result valid for write-back.
- `wb_data` output REG_SIZE: result.
- `wb_rd` output 5: destination register.
- `wb_regwrite` output 1: write-back enable.
- `wb_exc` output 1: exception flag.
- `wb_exc_cause` output 2: 0 none, 1 overflow, 2 misaligned load, 3 misaligned store.

## Operation
- State machine: IDLE and WAIT.
  - `ex_ready = (state == IDLE)`.
  - `dc_req = (state == WAIT)`.
- IDLE, accepted non-memory op:
  - Next cycle: `wb_valid=1`, `wb_data=ex_alu_out`, `wb_rd=ex_rd`.
  - `wb_regwrite = ex_regwrite && !ex_overflow`.
  - `ex_overflow` gives `wb_exc=1` with cause 1.
- IDLE, accepted memory op, aligned (LDB, STB, or LDW/STW with addr[1:0]=0):
  - Latch address, data, rd and op; go to WAIT.
  - `wb_valid` is 0 while waiting.
- IDLE, accepted misaligned LDW/STW:
  - No cache request.
  - Next cycle: `wb_valid=1`, `wb_exc=1`, cause 2 or 3, `wb_regwrite=0`, `wb_data=` the faulting address.
- Outputs held stable in WAIT: `dc_addr`, `dc_we`, `dc_wdata`, `dc_be`.
- Store encoding:
  - STB: `dc_be = 4'b0001 << addr[1:0]`, `dc_wdata` = low byte replicated to all four lanes.
  - STW: `dc_be = 4'hF`.
- WAIT, `dc_ack=1`:
  - Return to IDLE next cycle and assert `wb_valid` that cycle.
  - LDW: `wb_data = dc_rdata`.
  - LDB: byte `addr[1:0]` (little-endian), sign-extended to 32 bits.
  - Stores: `wb_regwrite=0`, `wb_data = address`.
- `flush`:
  - In IDLE: the op accepted that cycle is dropped; `wb_valid=0` next cycle.
  - In WAIT: `dc_req` stays asserted until `dc_ack`, because a cache transaction is never abandoned. The completed result is discarded (`wb_valid=0`). A flush with ack in the same cycle also discards.
- `wb_*` outputs are valid only when `wb_valid=1`. `wb_valid` is a single-cycle pulse per op. There is no write-back backpressure.

## Timing
- Reset (`rst_n=0` at an edge) puts the stage in IDLE and drives all of:
  - `wb_valid=0`, `wb_data=0`, `wb_rd=0`, `wb_regwrite=0`, `wb_exc=0`, `wb_exc_cause=0`.
  - `dc_req=0`, `dc_we=0`, `dc_addr=0`, `dc_wdata=0`, `dc_be=0`.
  - `ex_ready=1` from the first cycle after reset.
- Reset mid-WAIT: return to IDLE and drop `dc_req` immediately. The cache must also be reset.
- Non-memory op latency: 1 cycle.
- Memory op accepted at cycle T:
  - `dc_req` high from T+1.
  - Ack at cycle A (A ≥ T+1): `wb_valid` and `ex_ready` high at A+1, `dc_req` low at A+1.
  - Minimum load-use latency is 2 cycles.
- Back-to-back: a new op can be accepted at A+1, so with a zero-wait cache the request rate is one memory op every 2 cycles.
- `dc_ack` while in IDLE is ignored.

## Test plan
- Reset, then ADD result `32'h0000_0010`, rd=3, no overflow → next cycle `wb_valid=1`, `wb_data=32'h10`, `wb_rd=3`, `wb_regwrite=1`; `dc_req` never asserted.
- LDB at addr `32'h103`, cache returns `32'h80AB_CDEF` after 3 wait cycles → `ex_ready` low 4 cycles, `dc_addr=32'h100`, `wb_data=32'hFFFF_FF80`.
- STB at `32'h201` with data `32'h1234_5678` → `dc_we=1`, `dc_be=4'b0010`, `dc_wdata=32'h7878_7878`, `wb_regwrite=0`.
- LDW at `32'h102` → no `dc_req`; next cycle `wb_exc=1`, cause 2, `wb_data=32'h102`, `wb_regwrite=0`.
- `flush` during WAIT of an LDW, ack 2 cycles later → `dc_req` held until ack; no `wb_valid` pulse; `ex_ready` returns high the cycle after ack.
- ADD with `ex_overflow=1`, then `rst_n` low during a later WAIT → first op gives `wb_exc=1`, cause 1, `wb_regwrite=0`; after reset all outputs read 0 and `ex_ready=1`.

Source files
------------

// File: rtl/mem_stage_if.sv
// Execute-side, data-cache and write-back signals of the memory stage.
// The master modport is the stage itself; slave is the surrounding pipeline/cache.
interface mem_stage_if #(
    parameter int REG_SIZE = 32
);
    logic                ex_valid;
    logic                ex_ready;
    logic [4:0]          ex_aluop;
    logic [REG_SIZE-1:0] ex_alu_out;
    logic [REG_SIZE-1:0] ex_store_data;
    logic [4:0]          ex_rd;
    logic                ex_regwrite;
    logic                ex_overflow;
    logic                flush;

    logic                dc_req;
    logic                dc_we;
    logic [REG_SIZE-1:0] dc_addr;
    logic [REG_SIZE-1:0] dc_wdata;
    logic [3:0]          dc_be;
    logic                dc_ack;
    logic [REG_SIZE-1:0] dc_rdata;

    logic                wb_valid;
    logic [REG_SIZE-1:0] wb_data;
    logic [4:0]          wb_rd;
    logic                wb_regwrite;
    logic                wb_exc;
    logic [1:0]          wb_exc_cause;

    modport master (
        input  ex_valid, ex_aluop, ex_alu_out, ex_store_data, ex_rd,
               ex_regwrite, ex_overflow, flush, dc_ack, dc_rdata,
        output ex_ready, dc_req, dc_we, dc_addr, dc_wdata, dc_be,
               wb_valid, wb_data, wb_rd, wb_regwrite, wb_exc, wb_exc_cause
    );

    modport slave (
        output ex_valid, ex_aluop, ex_alu_out, ex_store_data, ex_rd,
               ex_regwrite, ex_overflow, flush, dc_ack, dc_rdata,
        input  ex_ready, dc_req, dc_we, dc_addr, dc_wdata, dc_be,
               wb_valid, wb_data, wb_rd, wb_regwrite, wb_exc, wb_exc_cause
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: runs a req/ack data-cache transaction for byte/word loads
// and stores, stalling execute meanwhile; other ops pass to write-back in one cycle.
module mem_stage #(
    parameter int         REG_SIZE  = 32,
    parameter logic [4:0] ALUOP_LDB = 5'd16,
    parameter logic [4:0] ALUOP_LDW = 5'd17,
    parameter logic [4:0] ALUOP_STB = 5'd18,
    parameter logic [4:0] ALUOP_STW = 5'd19
) (
    input logic         clk,
    input logic         rst_n,
    mem_stage_if.master bus
);
    typedef enum logic {IDLE, WAIT} state_e;

    state_e              state_q, state_d;
    logic [REG_SIZE-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]          be_q, be_d;
    logic                we_q, we_d, ldb_q, ldb_d, regwrite_q, regwrite_d, kill_q, kill_d;
    logic [4:0]          rd_q, rd_d;

    logic                wb_valid_q, wb_valid_d, wb_regwrite_q, wb_regwrite_d;
    logic                wb_exc_q, wb_exc_d;
    logic [1:0]          wb_cause_q, wb_cause_d;
    logic [REG_SIZE-1:0] wb_data_q, wb_data_d;
    logic [4:0]          wb_rd_q, wb_rd_d;

    logic is_ldb, is_ldw, is_stb, is_stw, is_mem, misaligned, accept;
    logic [7:0] ld_byte;

    always_comb begin
        is_ldb     = (bus.ex_aluop == ALUOP_LDB);
        is_ldw     = (bus.ex_aluop == ALUOP_LDW);
        is_stb     = (bus.ex_aluop == ALUOP_STB);
        is_stw     = (bus.ex_aluop == ALUOP_STW);
        is_mem     = is_ldb || is_ldw || is_stb || is_stw;
        misaligned = (is_ldw || is_stw) && (bus.ex_alu_out[1:0] != 2'b00);
        accept     = bus.ex_valid && (state_q == IDLE);
        case (addr_q[1:0])
            2'd0:    ld_byte = bus.dc_rdata[7:0];
            2'd1:    ld_byte = bus.dc_rdata[15:8];
            2'd2:    ld_byte = bus.dc_rdata[23:16];
            default: ld_byte = bus.dc_rdata[31:24];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            be_q          <= '0;
            we_q          <= 1'b0;
            ldb_q         <= 1'b0;
            regwrite_q    <= 1'b0;
            kill_q        <= 1'b0;
            rd_q          <= '0;
            wb_valid_q    <= 1'b0;
            wb_data_q     <= '0;
            wb_rd_q       <= '0;
            wb_regwrite_q <= 1'b0;
            wb_exc_q      <= 1'b0;
            wb_cause_q    <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            be_q          <= be_d;
            we_q          <= we_d;
            ldb_q         <= ldb_d;
            regwrite_q    <= regwrite_d;
            kill_q        <= kill_d;
            rd_q          <= rd_d;
            wb_valid_q    <= wb_valid_d;
            wb_data_q     <= wb_data_d;
            wb_rd_q       <= wb_rd_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_exc_q      <= wb_exc_d;
            wb_cause_q    <= wb_cause_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        be_d          = be_q;
        we_d          = we_q;
        ldb_d         = ldb_q;
        regwrite_d    = regwrite_q;
        kill_d        = kill_q;
        rd_d          = rd_q;
        wb_valid_d    = 1'b0;
        wb_data_d     = wb_data_q;
        wb_rd_d       = wb_rd_q;
        wb_regwrite_d = wb_regwrite_q;
        wb_exc_d      = wb_exc_q;
        wb_cause_d    = wb_cause_q;
        case (state_q)
            IDLE: begin
                if (accept && !bus.flush) begin
                    if (is_mem && !misaligned) begin
                        state_d    = WAIT;
                        addr_d     = bus.ex_alu_out;
                        rd_d       = bus.ex_rd;
                        regwrite_d = bus.ex_regwrite;
                        ldb_d      = is_ldb;
                        we_d       = is_stb || is_stw;
                        be_d       = (is_ldb || is_stb) ? (4'b0001 << bus.ex_alu_out[1:0]) : 4'hF;
                        wdata_d    = is_stb ? {4{bus.ex_store_data[7:0]}} :
                                     is_stw ? bus.ex_store_data : '0;
                        kill_d     = 1'b0;
                    end else begin
                        wb_valid_d    = 1'b1;
                        wb_data_d     = bus.ex_alu_out;
                        wb_rd_d       = bus.ex_rd;
                        if (misaligned) begin
                            wb_regwrite_d = 1'b0;
                            wb_exc_d      = 1'b1;
                            wb_cause_d    = is_ldw ? 2'd2 : 2'd3;
                        end else begin
                            wb_regwrite_d = bus.ex_regwrite && !bus.ex_overflow;
                            wb_exc_d      = bus.ex_overflow;
                            wb_cause_d    = bus.ex_overflow ? 2'd1 : 2'd0;
                        end
                    end
                end
            end
            WAIT: begin
                // A flush never aborts the cache transaction; it only discards the result.
                if (bus.flush) kill_d = 1'b1;
                if (bus.dc_ack) begin
                    state_d = IDLE;
                    kill_d  = 1'b0;
                    if (!kill_q && !bus.flush) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_exc_d   = 1'b0;
                        wb_cause_d = 2'd0;
                        if (we_q) begin
                            wb_regwrite_d = 1'b0;
                            wb_data_d     = addr_q;
                        end else begin
                            wb_regwrite_d = regwrite_q;
                            wb_data_d     = ldb_q ? {{(REG_SIZE-8){ld_byte[7]}}, ld_byte} : bus.dc_rdata;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ex_ready     = (state_q == IDLE);
        bus.dc_req       = (state_q == WAIT);
        bus.dc_we        = we_q;
        bus.dc_addr      = {addr_q[REG_SIZE-1:2], 2'b00};
        bus.dc_wdata     = wdata_q;
        bus.dc_be        = be_q;
        bus.wb_valid     = wb_valid_q;
        bus.wb_data      = wb_data_q;
        bus.wb_rd        = wb_rd_q;
        bus.wb_regwrite  = wb_regwrite_q;
        bus.wb_exc       = wb_exc_q;
        bus.wb_exc_cause = wb_cause_q;
    end
endmodule
